// File: rtl/clz_pkg.sv
// Shared width defaults and the per-stage payload carried through lz_expand.
// The payload is sized for the default word width.
package clz_pkg;

    localparam int CLZ_WI_SZ = 32;
    localparam int CLZ_WO_SZ = $clog2(CLZ_WI_SZ) + 1;

    typedef struct packed {
        logic [CLZ_WI_SZ-1:0] data;
        logic [CLZ_WO_SZ-1:0] cnt;
        logic                 zero;
        logic                 err;
        logic                 valid;
    } lz_stage_t;

endpackage

// File: rtl/lz_expand_stage.sv
// One barrel-shifter stage: shift right by SHIFT when the low count bit is
// set, consume that bit, and register the payload under the global enable.
module lz_expand_stage
    import clz_pkg::*;
#(
    parameter int SHIFT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  lz_stage_t d,
    output lz_stage_t q
);

    lz_stage_t nxt;

    always_comb begin
        nxt     = d;
        nxt.cnt = d.cnt >> 1;
        if (d.cnt[0]) begin
            nxt.data = d.data >> SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/lz_expand.sv
// Pipelined inverse of leading-zero normalize: out_data = in_mant >> in_cnt.
// Define LZ_EXPAND_CHECK_EN to flag beats whose mantissa is not normalized.
module lz_expand
    import clz_pkg::*;
#(
    parameter int WI_SZ = CLZ_WI_SZ,
    parameter int WO_SZ = $clog2(WI_SZ) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WI_SZ-1:0] in_mant,
    input  logic [WO_SZ-1:0] in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WI_SZ-1:0] out_data,
    output logic             out_err
);

    localparam int S = $clog2(WI_SZ);

    logic      en;
    lz_stage_t head;
    lz_stage_t last;
    lz_stage_t pipe [S];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Counts of WI_SZ and above saturate to zero rather than wrapping.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.data  = CLZ_WI_SZ'(in_mant);
        head.cnt   = CLZ_WO_SZ'(in_cnt[S-1:0]);
        head.zero  = 32'(in_cnt) >= WI_SZ;
`ifdef LZ_EXPAND_CHECK_EN
        head.err   = (32'(in_cnt) < WI_SZ) ? !in_mant[WI_SZ-1]
                                           : (in_mant != '0);
`endif
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        if (k == 0) begin : g_first
            lz_expand_stage #(
                .SHIFT(1 << k)
            ) u_stage (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (en),
                .d    (head),
                .q    (pipe[k])
            );
        end else begin : g_next
            lz_expand_stage #(
                .SHIFT(1 << k)
            ) u_stage (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (en),
                .d    (pipe[k-1]),
                .q    (pipe[k])
            );
        end
    end

    assign last      = pipe[S-1];
    assign out_valid = last.valid;
    assign out_data  = last.zero ? '0 : last.data[WI_SZ-1:0];

`ifdef LZ_EXPAND_CHECK_EN
    assign out_err = last.err;

    always_comb begin
        assert (last.cnt == '0);
    end
`else
    assign out_err = 1'b0;

    // Every count bit is consumed by the last stage; err never leaves 0.
    always_comb begin
        assert ({last.cnt, last.err} == '0);
    end
`endif

endmodule

// File: tb/tb_lz_expand.sv
// Directed and random checks for lz_expand at WI_SZ=32.
// Expected err values follow LZ_EXPAND_CHECK_EN when it is defined.
module tb_lz_expand;

    localparam int WI = 32;
    localparam int WO = 6;
`ifdef LZ_EXPAND_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WI-1:0] in_mant = '0;
    logic [WO-1:0] in_cnt = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WI-1:0] out_data;
    logic          out_err;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lz_expand #(
        .WI_SZ(WI),
        .WO_SZ(WO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mant  (in_mant),
        .in_cnt   (in_cnt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    function automatic int lzc(logic [31:0] w);
        for (int i = 31; i >= 0; i--) begin
            if (w[i]) return 31 - i;
        end
        return 32;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_mant = 32'h8000_0000;
        out_ready = 1'b1;
        #2;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data got %h want 0", out_data);
        end
        vectors++;
        if (out_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got err=%b valid=%b want 0/0",
                     out_err, out_valid);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] m;
        logic [5:0]  c;
        logic [31:0] d;
        bit          bad;
    } vec_t;

    task automatic test_basic();
        vec_t tbl [10];
        int lat;
        logic [31:0] got;
        logic gerr;
        tbl = '{
            '{32'h8000_0000, 6'd0,  32'h8000_0000, 1'b0},
            '{32'h8000_0000, 6'd31, 32'h0000_0001, 1'b0},
            '{32'h0000_0000, 6'd32, 32'h0000_0000, 1'b0},
            '{32'h8000_0000, 6'd40, 32'h0000_0000, 1'b1},
            '{32'h4000_0000, 6'd3,  32'h0800_0000, 1'b1},
            '{32'hC000_0000, 6'd4,  32'h0C00_0000, 1'b0},
            '{32'hA500_0000, 6'd7,  32'h014A_0000, 1'b0},
            '{32'h8000_0001, 6'd16, 32'h0000_8000, 1'b0},
            '{32'hFFFF_FFFF, 6'd63, 32'h0000_0000, 1'b1},
            '{32'h1234_5678, 6'd0,  32'h1234_5678, 1'b1}
        };
        for (int v = 0; v < 10; v++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid = 1'b1;
            in_mant = tbl[v].m;
            in_cnt = tbl[v].c;
            lat = 0;
            got = 'x;
            gerr = 1'bx;
            for (int n = 1; n <= 12 && lat == 0; n++) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                if (out_valid === 1'b1) begin
                    lat = n;
                    got = out_data;
                    gerr = out_err;
                end
            end
            vectors++;
            if (lat != 5) begin
                errors++;
                $display("FAIL basic%0d_latency got %0d want 5", v, lat);
            end
            vectors++;
            if (got !== tbl[v].d) begin
                errors++;
                $display("FAIL basic%0d_data got %h want %h",
                         v, got, tbl[v].d);
            end
            vectors++;
            if (gerr !== (CHK & tbl[v].bad)) begin
                errors++;
                $display("FAIL basic%0d_err got %b want %b",
                         v, gerr, CHK & tbl[v].bad);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] bm [8];
        logic [5:0]  bc [8];
        logic [31:0] prev_data;
        logic [31:0] want;
        bit stalled;
        int sent;
        int got;
        sent = 0;
        got = 0;
        stalled = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 8; i++) begin
            bm[i] = 32'h8000_0000 | (32'(i) << 4) | 32'h0100_0000;
            bc[i] = 6'(i * 3);
        end
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 9);
            in_valid = sent < 8;
            if (sent < 8) begin
                in_mant = bm[sent];
                in_cnt = bc[sent];
            end
            @(negedge clk);
            if (stalled) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL b2b_hold got %b/%h want 1/%h",
                             out_valid, out_data, prev_data);
                end
            end
            if (out_valid && !out_ready) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_in_ready got %b want 0", in_ready);
                end
            end
            stalled = out_valid && !out_ready;
            prev_data = out_data;
            if (in_valid && in_ready) begin
                q.push_back(bm[sent] >> bc[sent]);
                sent++;
            end
            if (out_valid && out_ready) begin
                want = (q.size() > 0) ? q.pop_front() : 32'hxxxx_xxxx;
                vectors++;
                if (out_data !== want) begin
                    errors++;
                    $display("FAIL b2b_beat%0d got %h want %h",
                             got, out_data, want);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (got != 8 || sent != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d/%0d want 8/8", got, sent);
        end
    endtask

    task automatic test_reset_flight();
        int seen;
        int lat;
        logic [31:0] got;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mant = 32'h8000_0000;
            in_cnt = 6'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flight_reset got valid=%b ready=%b want 0/1",
                     out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flight_drop got %0d beats want 0", seen);
        end
        in_valid = 1'b1;
        in_mant = 32'h8000_0000;
        in_cnt = 6'd2;
        lat = 0;
        got = 'x;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                lat = n;
                got = out_data;
            end
        end
        vectors++;
        if (lat != 5 || got !== 32'h2000_0000) begin
            errors++;
            $display("FAIL flight_new got lat=%0d data=%h want 5/20000000",
                     lat, got);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_roundtrip();
        localparam int N = 10000;
        logic [31:0] q[$];
        logic [31:0] w;
        logic [31:0] want;
        bit pend;
        int c;
        int sent;
        int got;
        sent = 0;
        got = 0;
        pend = 1'b0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 60000 && got < N; cyc++) begin
            if (!pend && sent < N && $urandom_range(0, 9) < 8) begin
                w = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 49) == 0) w = '0;
                c = lzc(w);
                in_mant = (c >= 32) ? 32'h0 : (w << c);
                in_cnt = 6'(c);
                in_valid = 1'b1;
                pend = 1'b1;
            end else if (!pend) begin
                in_valid = 1'b0;
            end
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(w);
                sent++;
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                want = (q.size() > 0) ? q.pop_front() : 32'hxxxx_xxxx;
                vectors++;
                if (out_data !== want || out_err !== 1'b0) begin
                    errors++;
                    $display("FAIL roundtrip%0d got %h/%b want %h/0",
                             got, out_data, out_err, want);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++;
        if (got != N) begin
            errors++;
            $display("FAIL roundtrip_count got %0d want %0d", got, N);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_flight();
        test_roundtrip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
